host_rsp_model: RTL and testbench

HOST_RSP_MODEL -- requirements
Module: host_rsp_model

---
 rtl/host_rsp_model.sv | 151 +++++++++++++++
 tb/tb_host_rsp_model.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/host_rsp_model.sv
// host_rsp_model: behavioural host-memory responder.
//
// Each accepted request travels down a fixed `latency`-stage valid/sid pipeline and lands
// in a `depth`-entry response FIFO. Responses are returned strictly in acceptance order.
// o_cnt counts every request between acceptance and completion (pipeline plus FIFO).
// Because i_req_r is held low once o_cnt reaches `depth`, the pipeline never has to
// stall and the FIFO can never overflow.
//
// Ports:
//   clk       - single clock; all state updates on its rising edge
//   reset     - asynchronous active-low reset
//   i_req_v   - request valid
//   i_req_r   - request ready (o_cnt < depth, only after reset has been released)
//   i_req_sid - requesting stream id
//   i_req_ea  - requested effective address (used only by the alignment check)
//   o_rsp_v   - response valid
//   o_rsp_r   - response ready
//   o_rsp_sid - stream id of the response at the FIFO head (0 when no response is valid)
//   o_cnt     - number of outstanding requests
//   o_err     - sticky misaligned-request flag
//
// Optional feature: define HOST_RSP_ALIGN_CHK_EN to enable the cache-line alignment
// check. Without it, o_err is tied to 0.
module host_rsp_model #(
  parameter int unsigned nstrms       = 64,
  parameter int unsigned nstrms_width = $clog2(nstrms),
  parameter int unsigned addr_width   = 64,
  parameter int unsigned cache_line   = 128,
  parameter int unsigned latency      = 8,
  parameter int unsigned depth        = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_req_v,
  output logic                      i_req_r,
  input  logic [nstrms_width-1:0]   i_req_sid,
  input  logic [addr_width-1:0]     i_req_ea,
  output logic                      o_rsp_v,
  input  logic                      o_rsp_r,
  output logic [nstrms_width-1:0]   o_rsp_sid,
  output logic [$clog2(depth):0]    o_cnt,
  output logic                      o_err
);

  localparam int unsigned PtrW = $clog2(depth);
  localparam int unsigned CntW = PtrW + 1;

  // live_q is cleared by reset and set by the first clock edge after release, so ready
  // only rises once the block is really running.
  logic                    live_q;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [latency-1:0]      pipe_v_q, pipe_v_d;
  logic [nstrms_width-1:0] pipe_sid_q [latency];
  // Pointers carry one extra bit so that full and empty are distinguishable.
  logic [CntW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [nstrms_width-1:0] mem_q [depth];

  logic accept;
  logic complete;
  logic push;
  logic fifo_v;

  assign i_req_r  = live_q & (cnt_q < CntW'(depth));
  assign accept   = i_req_v & i_req_r;
  assign fifo_v   = (wr_ptr_q != rd_ptr_q);
  assign complete = fifo_v & o_rsp_r;
  assign push     = pipe_v_q[latency-1];

  assign o_rsp_v   = fifo_v;
  assign o_rsp_sid = fifo_v ? mem_q[rd_ptr_q[PtrW-1:0]] : '0;
  assign o_cnt     = cnt_q;

  always_comb begin
    pipe_v_d    = '0;
    pipe_v_d[0] = accept;
    for (int unsigned i = 1; i < latency; i++) begin
      pipe_v_d[i] = pipe_v_q[i-1];
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    unique case ({accept, complete})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
    if (push) begin
      wr_ptr_d = wr_ptr_q + CntW'(1);
    end
    if (complete) begin
      rd_ptr_d = rd_ptr_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      live_q   <= 1'b0;
      cnt_q    <= '0;
      pipe_v_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      live_q   <= 1'b1;
      cnt_q    <= cnt_d;
      pipe_v_q <= pipe_v_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Payload storage needs no reset: it is only observed behind a valid bit or pointer.
  always_ff @(posedge clk) begin
    pipe_sid_q[0] <= i_req_sid;
    for (int unsigned i = 1; i < latency; i++) begin
      pipe_sid_q[i] <= pipe_sid_q[i-1];
    end
    if (push) begin
      mem_q[wr_ptr_q[PtrW-1:0]] <= pipe_sid_q[latency-1];
    end
  end

  // The address only feeds the optional alignment check.
  logic unused_ea;
  assign unused_ea = ^i_req_ea;

`ifdef HOST_RSP_ALIGN_CHK_EN
  localparam int unsigned LineLsb = $clog2(cache_line);

  logic err_q, err_d;

  assign err_d = err_q | (accept & (|i_req_ea[LineLsb-1:0]));
  assign o_err = err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
`else
  logic unused_line;
  assign unused_line = (cache_line == 0);
  assign o_err       = 1'b0;
`endif

endmodule

// File: tb/tb_host_rsp_model.sv
// Self-checking bench for host_rsp_model. The reference model is a queue of accepted
// requests, each tagged with the cycle at which it becomes visible at the FIFO head.
module tb_host_rsp_model;

  localparam int unsigned LAT      = 8;
  localparam int unsigned DEPTH    = 16;
  localparam int unsigned SW       = 6;
  localparam int unsigned AW       = 64;
  localparam int unsigned LINE_LSB = 7;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req_v;
  logic          i_req_r;
  logic [SW-1:0] i_req_sid;
  logic [AW-1:0] i_req_ea;
  logic          o_rsp_v;
  logic          o_rsp_r;
  logic [SW-1:0] o_rsp_sid;
  logic [4:0]    o_cnt;
  logic          o_err;

  host_rsp_model #(
    .nstrms    (64),
    .addr_width(AW),
    .cache_line(128),
    .latency   (LAT),
    .depth     (DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .i_req_v  (i_req_v),
    .i_req_r  (i_req_r),
    .i_req_sid(i_req_sid),
    .i_req_ea (i_req_ea),
    .o_rsp_v  (o_rsp_v),
    .o_rsp_r  (o_rsp_r),
    .o_rsp_sid(o_rsp_sid),
    .o_cnt    (o_cnt),
    .o_err    (o_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [SW-1:0] sid;
    int unsigned   due;
  } ent_t;

  ent_t        m_q[$];
  bit          m_live;
  bit          m_err;
  int unsigned cyc;
  int          n_checks;
  int          n_pass;

  function automatic bit m_rsp_v();
    return (m_q.size() > 0) && (m_q[0].due <= cyc);
  endfunction

  // Advance one clock and update the reference model with this cycle's handshakes.
  task automatic tick();
    bit acc;
    bit cmp;
    acc = i_req_v && m_live && (m_q.size() < DEPTH);
    cmp = m_rsp_v() && o_rsp_r;
    @(posedge clk);
    cyc++;
    if (cmp) void'(m_q.pop_front());
    if (acc) m_q.push_back('{sid: i_req_sid, due: cyc + LAT});
`ifdef HOST_RSP_ALIGN_CHK_EN
    if (acc && (i_req_ea[LINE_LSB-1:0] != '0)) m_err = 1'b1;
`endif
    m_live = 1'b1;
    #1;
  endtask

  task automatic model_reset();
    m_q.delete();
    m_live = 1'b0;
    m_err  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; i_req_v = 1'b0; i_req_sid = '0; i_req_ea = '0; o_rsp_r = 1'b0;
    model_reset();
    repeat (2) begin @(posedge clk); cyc++; end
    #1;
    n_checks++; if (i_req_r !== 1'b0) $display("FAIL rst_ready got %b want 0", i_req_r); else n_pass++;
    n_checks++; if (o_rsp_v !== 1'b0) $display("FAIL rst_rsp_v got %b want 0", o_rsp_v); else n_pass++;
    n_checks++; if (o_rsp_sid !== '0) $display("FAIL rst_sid got %0d want 0", o_rsp_sid); else n_pass++;
    n_checks++; if (o_cnt !== 5'd0) $display("FAIL rst_cnt got %0d want 0", o_cnt); else n_pass++;
    n_checks++; if (o_err !== 1'b0) $display("FAIL rst_err got %b want 0", o_err); else n_pass++;
    reset = 1'b1;
    #1;
    n_checks++; if (i_req_r !== 1'b0) $display("FAIL rel_ready_early got %b want 0", i_req_r); else n_pass++;
    tick();
    n_checks++; if (i_req_r !== 1'b1) $display("FAIL rel_ready got %b want 1", i_req_r); else n_pass++;
  endtask

  task automatic test_single();
    int unsigned   t0;
    int            first;
    int            hi;
    logic [SW-1:0] sid_seen;
    first = -1; hi = 0; sid_seen = '0;
    o_rsp_r = 1'b1; i_req_v = 1'b1; i_req_sid = 6'd1; i_req_ea = '0;
    tick();
    t0 = cyc;
    i_req_v = 1'b0;
    n_checks++; if (o_cnt !== 5'd1) $display("FAIL single_cnt1 got %0d want 1", o_cnt); else n_pass++;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (o_rsp_v) begin
        if (first < 0) begin
          first    = int'(cyc - t0);
          sid_seen = o_rsp_sid;
        end
        hi++;
      end
    end
    n_checks++; if (first != 8) $display("FAIL single_latency got %0d want 8", first); else n_pass++;
    n_checks++; if (hi != 1) $display("FAIL single_width got %0d want 1", hi); else n_pass++;
    n_checks++; if (sid_seen !== 6'd1) $display("FAIL single_sid got %0d want 1", sid_seen); else n_pass++;
    n_checks++; if (o_cnt !== 5'd0) $display("FAIL single_cnt0 got %0d want 0", o_cnt); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [SW-1:0] sids [3];
    logic [SW-1:0] got_sid [16];
    int            got_t [16];
    int            n;
    int unsigned   t0;
    sids[0] = 6'd1; sids[1] = 6'd17; sids[2] = 6'd2;
    n = 0; t0 = 0;
    o_rsp_r = 1'b1;
    for (int j = 0; j < 3; j++) begin
      i_req_v = 1'b1; i_req_sid = sids[j];
      tick();
      if (j == 0) t0 = cyc;
    end
    i_req_v = 1'b0;
    for (int k = 0; k < 14; k++) begin
      tick();
      if (o_rsp_v && n < 16) begin
        got_sid[n] = o_rsp_sid;
        got_t[n]   = int'(cyc - t0);
        n++;
      end
    end
    n_checks++; if (n != 3) $display("FAIL b2b_count got %0d want 3", n); else n_pass++;
    for (int j = 0; j < 3 && j < n; j++) begin
      n_checks++;
      if (got_t[j] != 8 + j) $display("FAIL b2b_time[%0d] got %0d want %0d", j, got_t[j], 8 + j);
      else n_pass++;
      n_checks++;
      if (got_sid[j] !== sids[j]) $display("FAIL b2b_sid[%0d] got %0d want %0d", j, got_sid[j], sids[j]);
      else n_pass++;
    end
  endtask

  task automatic test_fill();
    logic [SW-1:0] offered [20];
    logic [SW-1:0] got [32];
    int            acc_n;
    int            n;
    acc_n = 0; n = 0;
    o_rsp_r = 1'b0;
    for (int j = 0; j < 20; j++) begin
      offered[j] = SW'($urandom);
      i_req_v = 1'b1; i_req_sid = offered[j];
      if (i_req_r) acc_n++;
      tick();
    end
    i_req_v = 1'b0;
    n_checks++; if (acc_n != 16) $display("FAIL fill_accepts got %0d want 16", acc_n); else n_pass++;
    n_checks++; if (i_req_r !== 1'b0) $display("FAIL fill_ready got %b want 0", i_req_r); else n_pass++;
    n_checks++; if (o_cnt !== 5'd16) $display("FAIL fill_cnt got %0d want 16", o_cnt); else n_pass++;
    tick();
    n_checks++;
    if (o_rsp_v !== 1'b1 || o_rsp_sid !== offered[0])
      $display("FAIL fill_hold got v=%b sid=%0d want v=1 sid=%0d", o_rsp_v, o_rsp_sid, offered[0]);
    else n_pass++;
    o_rsp_r = 1'b1;
    for (int k = 0; k < 30; k++) begin
      if (o_rsp_v) begin
        if (n < 32) got[n] = o_rsp_sid;
        n++;
      end
      tick();
    end
    n_checks++; if (n != 16) $display("FAIL drain_count got %0d want 16", n); else n_pass++;
    for (int j = 0; j < 16 && j < n; j++) begin
      n_checks++;
      if (got[j] !== offered[j]) $display("FAIL drain_sid[%0d] got %0d want %0d", j, got[j], offered[j]);
      else n_pass++;
    end
    n_checks++; if (i_req_r !== 1'b1) $display("FAIL drain_ready got %b want 1", i_req_r); else n_pass++;
  endtask

  task automatic test_full_complete();
    o_rsp_r = 1'b0;
    for (int j = 0; j < 16; j++) begin
      i_req_v = 1'b1; i_req_sid = SW'($urandom);
      tick();
    end
    i_req_v = 1'b0;
    repeat (LAT) tick();
    n_checks++; if (o_cnt !== 5'd16) $display("FAIL full_cnt got %0d want 16", o_cnt); else n_pass++;
    o_rsp_r = 1'b1; i_req_v = 1'b1; i_req_sid = SW'($urandom);
    #1;
    n_checks++; if (i_req_r !== 1'b0) $display("FAIL full_ready got %b want 0", i_req_r); else n_pass++;
    tick();
    i_req_v = 1'b0;
    n_checks++; if (o_cnt !== 5'd15) $display("FAIL full_nobypass got %0d want 15", o_cnt); else n_pass++;
    repeat (20) tick();
    n_checks++; if (o_cnt !== 5'd0) $display("FAIL full_drain got %0d want 0", o_cnt); else n_pass++;
  endtask

  task automatic test_reset_midflight();
    int seen;
    seen = 0;
    o_rsp_r = 1'b1;
    for (int j = 0; j < 5; j++) begin
      i_req_v = 1'b1; i_req_sid = SW'($urandom);
      tick();
    end
    i_req_v = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    model_reset();
    #2;
    n_checks++; if (i_req_r !== 1'b0) $display("FAIL mid_ready got %b want 0", i_req_r); else n_pass++;
    n_checks++; if (o_cnt !== 5'd0) $display("FAIL mid_cnt got %0d want 0", o_cnt); else n_pass++;
    n_checks++; if (o_rsp_v !== 1'b0) $display("FAIL mid_rsp_v got %b want 0", o_rsp_v); else n_pass++;
    @(posedge clk); cyc++; #1;
    reset = 1'b1;
    tick();
    n_checks++; if (i_req_r !== 1'b1) $display("FAIL mid_ready_back got %b want 1", i_req_r); else n_pass++;
    for (int k = 0; k < 20; k++) begin
      if (o_rsp_v) seen++;
      tick();
    end
    n_checks++; if (seen != 0) $display("FAIL mid_ghost got %0d want 0", seen); else n_pass++;
    n_checks++; if (o_cnt !== 5'd0) $display("FAIL mid_cnt_after got %0d want 0", o_cnt); else n_pass++;
  endtask

  task automatic test_align();
    bit err_exp;
    int err_bad;
    int seen9;
`ifdef HOST_RSP_ALIGN_CHK_EN
    err_exp = 1'b1;
`else
    err_exp = 1'b0;
`endif
    err_bad = 0; seen9 = 0;
    o_rsp_r = 1'b1; i_req_v = 1'b1; i_req_sid = 6'd5; i_req_ea = 64'd32768;
    tick();
    i_req_v = 1'b0;
    n_checks++; if (o_err !== 1'b0) $display("FAIL align_ok got %b want 0", o_err); else n_pass++;
    tick();
    n_checks++; if (o_err !== 1'b0) $display("FAIL align_ok2 got %b want 0", o_err); else n_pass++;
    i_req_v = 1'b1; i_req_sid = 6'd9; i_req_ea = 64'd32;
    tick();
    i_req_v = 1'b0; i_req_ea = '0;
    n_checks++; if (o_err !== err_exp) $display("FAIL align_err got %b want %b", o_err, err_exp); else n_pass++;
    for (int k = 0; k < 12; k++) begin
      if (o_rsp_v && o_rsp_sid == 6'd9) seen9++;
      if (o_err !== err_exp) err_bad++;
      tick();
    end
    n_checks++; if (err_bad != 0) $display("FAIL align_sticky got %0d want 0 bad cycles", err_bad); else n_pass++;
    n_checks++; if (seen9 != 1) $display("FAIL align_rsp got %0d want 1", seen9); else n_pass++;
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      i_req_v   = ($urandom % 4) != 0;
      i_req_sid = SW'($urandom);
      i_req_ea  = {$urandom, $urandom};
      if (($urandom % 8) != 0) i_req_ea[LINE_LSB-1:0] = '0;
      if (((k / 50) % 2) == 1) o_rsp_r = ($urandom % 4) == 0;
      else o_rsp_r = ($urandom % 4) != 0;
      tick();
      n_checks++;
      if (o_cnt !== 5'(m_q.size())) $display("FAIL rnd_cnt@%0d got %0d want %0d", cyc, o_cnt, m_q.size());
      else n_pass++;
      n_checks++;
      if (i_req_r !== (m_q.size() < DEPTH))
        $display("FAIL rnd_ready@%0d got %b want %b", cyc, i_req_r, m_q.size() < DEPTH);
      else n_pass++;
      n_checks++;
      if (o_rsp_v !== m_rsp_v()) $display("FAIL rnd_rsp_v@%0d got %b want %b", cyc, o_rsp_v, m_rsp_v());
      else n_pass++;
      if (m_rsp_v()) begin
        n_checks++;
        if (o_rsp_sid !== m_q[0].sid)
          $display("FAIL rnd_sid@%0d got %0d want %0d", cyc, o_rsp_sid, m_q[0].sid);
        else n_pass++;
      end
      n_checks++;
      if (o_err !== m_err) $display("FAIL rnd_err@%0d got %b want %b", cyc, o_err, m_err);
      else n_pass++;
    end
  endtask

  initial begin
    n_checks = 0; n_pass = 0; cyc = 0;
    m_live = 1'b0; m_err = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_fill();
    test_full_complete();
    test_reset_midflight();
    test_align();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
